// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Recovers pixel coordinates, data enable and captured pixel data from a
// raw VGA stream (hsync/vsync/rgb) sampled on a pixel strobe, and tracks
// whether the stream matches the expected timing.
//
// Ports:
//   clk, rst           sole clock (rising edge); async active-high reset
//   pix_en             one-clk pixel strobe; inputs sampled only when high
//   hsync_in, vsync_in active-high syncs, synchronous to clk
//   rgb_in[5:0]        {r[1:0],g[1:0],b[1:0]}
//   x, y               coordinates of the last sampled pixel
//   de_out             locked and inside the visible area
//   rgb_out            pixel captured with x/y; zero when de_out is low
//   locked             timing lock indicator
//   frame_start        one-clk pulse when locked and (x,y) becomes (0,0)
//   sync_err           one-clk pulse on any timing mismatch
//   err_count          saturating count of sync_err pulses
module vga_sync_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 2,
    parameter int V_TOTAL  = 524
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [5:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de_out,
    output logic [5:0] rgb_out,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [7:0] err_count
);

    // Column where hsync rises, the column just before it, and the first
    // column after hsync falls; likewise for lines.
    localparam logic [9:0] H_SEED = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_PRE  = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_FALL = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_SEED = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_FALL = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] Y_VIS  = 10'(V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, HTRACK, LOCKED} state_t;

    state_t     state, state_nxt;
    logic       hs_q, vs_q;
    logic [9:0] wd, wd_nxt;
    logic [5:0] rgb_q;
    logic [9:0] x_nxt, y_nxt;
    logic       hs_rise, hs_fall, vs_rise, vs_fall;
    logic       h_mis, v_mis, wd_trip, mismatch, fs_nxt;

    assign hs_rise = hsync_in & ~hs_q;
    assign hs_fall = ~hsync_in & hs_q;
    assign vs_rise = vsync_in & ~vs_q;
    assign vs_fall = ~vsync_in & vs_q;

    // Coordinate advance; x/y free-run in every state, hsync/vsync rises
    // re-seed them so they line up with the incoming stream.
    always_comb begin
        x_nxt = hs_rise ? H_SEED : ((x == H_LAST) ? 10'd0 : x + 10'd1);
        y_nxt = y;
        if (vs_rise)
            y_nxt = V_SEED;
        else if (!hs_rise && x == H_LAST)
            y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end

    // All mismatch sources fold into one flag so a cycle with several of
    // them still yields a single pulse and a single increment.
    always_comb begin
        h_mis   = (hs_rise && x != H_PRE) || (hs_fall && x_nxt != H_FALL);
        wd_trip = !hs_rise && (wd == 10'h3FF);
        v_mis   = 1'b0;
        if (state == HTRACK)
            v_mis = vs_rise && (x_nxt != 10'd0);
        else if (state == LOCKED)
            v_mis = (vs_rise && (x_nxt != 10'd0 || y_nxt != V_SEED)) ||
                    (vs_fall && (x_nxt != 10'd0 || y_nxt != V_FALL));
        mismatch = (state != SEARCH) && (h_mis || v_mis || wd_trip);
        fs_nxt   = (state == LOCKED) && !mismatch && x_nxt == 10'd0 && y_nxt == 10'd0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (hs_rise) state_nxt = HTRACK;
            HTRACK:  if (mismatch) state_nxt = SEARCH;
                     else if (vs_rise) state_nxt = LOCKED;
            LOCKED:  if (mismatch) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
        // Watchdog counts strobes since the last hsync rise while tracking.
        wd_nxt = (state == SEARCH || hs_rise || mismatch) ? 10'd0 : wd + 10'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= SEARCH;
        else if (pix_en)
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            x           <= '0;
            y           <= '0;
            wd          <= '0;
            rgb_q       <= '0;
            err_count   <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            if (pix_en) begin
                hs_q        <= hsync_in;
                vs_q        <= vsync_in;
                x           <= x_nxt;
                y           <= y_nxt;
                wd          <= wd_nxt;
                rgb_q       <= rgb_in;
                frame_start <= fs_nxt;
                sync_err    <= mismatch;
                if (mismatch && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end

    assign locked  = (state == LOCKED);
    assign de_out  = locked && (x < X_VIS) && (y < Y_VIS);
    assign rgb_out = de_out ? rgb_q : 6'd0;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 40x12 raster (16x6 visible,
// hsync columns 20..27, vsync lines 8..9). A stream generator drives
// pixels and pushes the expected outputs into a scoreboard queue; each
// test pops and compares after the strobe edge.
module tb_vga_sync_decoder;
    localparam int HA = 16, HF = 4, HS = 8, HT = 40;
    localparam int VA = 6, VF = 2, VS = 2, VT = 12;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst, pix_en, hsync_in, vsync_in;
    logic [5:0] rgb_in;
    logic [9:0] x, y;
    logic       de_out, locked, frame_start, sync_err;
    logic [5:0] rgb_out;
    logic [7:0] err_count;

    int checks = 0, failures = 0;
    int cyc = 0;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .rgb_in(rgb_in), .x(x), .y(y), .de_out(de_out),
        .rgb_out(rgb_out), .locked(locked), .frame_start(frame_start),
        .sync_err(sync_err), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic [5:0] rgb;
        logic       locked;
        logic       fs;
        logic       err;
        logic [7:0] ec;
    } obs_t;

    typedef struct packed {
        obs_t o;
        logic xy_chk;  // x/y/de/rgb known (locked and aligned)
        logic dr_chk;  // de/rgb known
    } exp_t;

    exp_t sb_q[$];

    // Generator / reference model state
    int         gx, gy, short_y;
    int         m_st;  // 0 search, 1 htrack, 2 locked
    int         m_wd;
    logic       m_hs, m_vs, m_skew, m_hs_off;
    logic [7:0] m_ec;

    function automatic obs_t sample();
        obs_t o;
        o.x = x; o.y = y; o.de = de_out; o.rgb = rgb_out; o.locked = locked;
        o.fs = frame_start; o.err = sync_err; o.ec = err_count;
        return o;
    endfunction

    function automatic obs_t mask_of(input exp_t e);
        obs_t m;
        m = '1;
        if (!e.xy_chk) begin m.x = '0; m.y = '0; end
        if (!e.dr_chk) begin m.de = 1'b0; m.rgb = '0; end
        return m;
    endfunction

    task automatic reset_model();
        m_st = 0; m_wd = 0; m_hs = 0; m_vs = 0; m_skew = 0; m_hs_off = 0;
        m_ec = '0; short_y = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_en = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        reset_model();
        gx = 0; gy = 0;
    endtask

    task automatic drive_raw(input logic hs, input logic vs, input logic [5:0] rgb,
                             input int gap, input exp_t e);
        repeat (gap - 1) begin @(posedge clk); #1; end
        hsync_in = hs; vsync_in = vs; rgb_in = rgb; pix_en = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        pix_en = 1'b0;
    endtask

    // Drive pixel (gx,gy) of a nominal raster and queue the expected result.
    task automatic gen_pixel(input int gap);
        logic hs, vs, hr, vr, mis;
        logic [5:0] rgb;
        exp_t e;
        int len;
        hs  = !m_hs_off && gx >= HA + HF && gx < HA + HF + HS;
        vs  = gy >= VA + VF && gy < VA + VF + VS;
        hr  = hs && !m_hs;
        vr  = vs && !m_vs;
        rgb = 6'(gx * 5 + gy * 11 + 1);
        mis = (m_st != 0) && ((hr && m_skew) || (!hr && m_wd == 1023));
        e = '0;
        e.o.fs = (m_st == 2) && !mis && gx == 0 && gy == 0;
        if (m_st == 0 || hr || mis) m_wd = 0; else m_wd++;
        if (mis) begin
            m_st = 0; e.o.err = 1'b1;
            if (m_ec != 8'hFF) m_ec++;
        end else if (m_st == 0) begin
            if (hr) m_st = 1;
        end else if (m_st == 1 && vr) begin
            m_st = 2;
        end
        if (hr) m_skew = 1'b0;
        e.o.locked = (m_st == 2);
        e.xy_chk   = e.o.locked && !m_skew;
        e.dr_chk   = !(e.o.locked && m_skew);
        e.o.x      = 10'(gx);
        e.o.y      = 10'(gy);
        e.o.de     = e.o.locked && gx < HA && gy < VA;
        e.o.rgb    = e.o.de ? rgb : 6'd0;
        e.o.ec     = m_ec;
        drive_raw(hs, vs, rgb, gap, e);
        m_hs = hs; m_vs = vs;
        len = (gy == short_y) ? HT - 1 : HT;
        gx++;
        if (gx >= len) begin
            gx = 0;
            if (gy == short_y) begin short_y = -1; m_skew = 1'b1; end
            gy = (gy + 1) % VT;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_en = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 6'h2A;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (sample() !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", sample());
        end
        do_reset();
    endtask

    task automatic test_clean();
        exp_t ex; obs_t got, m;
        int nfs = 0, de_cnt = 0, last_fs = -1;
        do_reset();
        for (int i = 0; i <= 3 * FRAME; i++) begin
            gen_pixel(4);
            ex = sb_q.pop_front(); got = sample(); m = mask_of(ex);
            checks++;
            if ((got & m) !== (ex.o & m)) begin
                failures++;
                $display("FAIL clean_pix i=%0d got=%h exp=%h", i, got & m, ex.o & m);
            end
            if (got.fs) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs !== FRAME * 4) begin
                        failures++;
                        $display("FAIL fs_period got=%0d exp=%0d", cyc - last_fs, FRAME * 4);
                    end
                end
                last_fs = cyc;
                nfs++;
            end
            if (nfs == 1 && got.de) de_cnt++;
        end
        checks++;
        if (nfs !== 3) begin failures++; $display("FAIL fs_count got=%0d exp=3", nfs); end
        checks++;
        if (de_cnt !== HA * VA) begin failures++; $display("FAIL de_count got=%0d exp=%0d", de_cnt, HA * VA); end
        checks++;
        if (err_count !== 8'd0) begin failures++; $display("FAIL clean_errs got=%0d exp=0", err_count); end
    endtask

    task automatic test_short_line();
        exp_t ex; obs_t got, m;
        int n_err = 0;
        do_reset();
        for (int i = 0; i < FRAME + FRAME + 2 * HT; i++) begin
            if (i == FRAME) short_y = 2;
            gen_pixel(2);
            ex = sb_q.pop_front(); got = sample(); m = mask_of(ex);
            checks++;
            if ((got & m) !== (ex.o & m)) begin
                failures++;
                $display("FAIL short_pix i=%0d got=%h exp=%h", i, got & m, ex.o & m);
            end
            if (got.err) begin
                n_err++;
                @(posedge clk); #1;
                checks++;
                if (sync_err !== 1'b0) begin failures++; $display("FAIL err_pulse_clear got=%b exp=0", sync_err); end
            end
        end
        checks++;
        if (n_err !== 1) begin failures++; $display("FAIL short_err_pulses got=%0d exp=1", n_err); end
        checks++;
        if (err_count !== 8'd1) begin failures++; $display("FAIL short_err_count got=%0d exp=1", err_count); end
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL short_relock got=%b exp=1", locked); end
    endtask

    task automatic test_watchdog();
        exp_t ex; obs_t got, m;
        int n_err = 0;
        do_reset();
        for (int i = 0; i < 9 * HT + 26 * HT + FRAME; i++) begin
            m_hs_off = (i >= 9 * HT && i < 35 * HT);
            gen_pixel(1);
            ex = sb_q.pop_front(); got = sample(); m = mask_of(ex);
            checks++;
            if ((got & m) !== (ex.o & m)) begin
                failures++;
                $display("FAIL wd_pix i=%0d got=%h exp=%h", i, got & m, ex.o & m);
            end
            if (got.err) n_err++;
        end
        checks++;
        if (n_err !== 1) begin failures++; $display("FAIL wd_err_pulses got=%0d exp=1", n_err); end
        checks++;
        if (err_count !== 8'd1) begin failures++; $display("FAIL wd_err_count got=%0d exp=1", err_count); end
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL wd_relock got=%b exp=1", locked); end
    endtask

    task automatic test_reset_midline();
        exp_t ex; obs_t got, m;
        do_reset();
        for (int i = 0; i < FRAME + 3 * HT + 10; i++) begin
            gen_pixel(1);
            ex = sb_q.pop_front(); got = sample(); m = mask_of(ex);
            checks++;
            if ((got & m) !== (ex.o & m)) begin
                failures++;
                $display("FAIL pre_rst_pix i=%0d got=%h exp=%h", i, got & m, ex.o & m);
            end
        end
        checks++;
        if ({locked, de_out} !== 2'b11) begin failures++; $display("FAIL pre_rst_lock got=%b exp=11", {locked, de_out}); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (sample() !== obs_t'(0)) begin
            failures++;
            $display("FAIL async_rst got=%h exp=0", sample());
        end
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < FRAME; i++) begin
            gen_pixel(1);
            ex = sb_q.pop_front(); got = sample(); m = mask_of(ex);
            checks++;
            if ((got & m) !== (ex.o & m)) begin
                failures++;
                $display("FAIL post_rst_pix i=%0d got=%h exp=%h", i, got & m, ex.o & m);
            end
        end
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL post_rst_relock got=%b exp=1", locked); end
    endtask

    task automatic test_saturation();
        exp_t e, ex; obs_t got, m;
        logic [7:0] ec = '0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                e = '0; e.xy_chk = 1'b0; e.dr_chk = 1'b1;
                if (ph == 1) begin
                    e.o.err = 1'b1;
                    if (ec != 8'hFF) ec++;
                end
                e.o.ec = ec;
                drive_raw(ph == 0, 1'b0, 6'h3F, 1, e);
                ex = sb_q.pop_front(); got = sample(); m = mask_of(ex);
                checks++;
                if ((got & m) !== (ex.o & m)) begin
                    failures++;
                    $display("FAIL sat_pix i=%0d ph=%0d got=%h exp=%h", i, ph, got & m, ex.o & m);
                end
            end
        end
        checks++;
        if (err_count !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", err_count); end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = '0;
        reset_model();
        gx = 0; gy = 0;
        test_reset();
        test_clean();
        test_short_line();
        test_watchdog();
        test_reset_midline();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
